// File: rtl/int_ctrl_if.sv
// Core-side bus of the interrupt controller: request lines, RETI/boundary
// handshake, context to save, and the redirect/restore results.
interface int_ctrl_if #(
    parameter int NIRQ  = 4,
    parameter int DEPTH = 4
);
    localparam int SP_W = $clog2(DEPTH) + 1;

    logic [NIRQ-1:0] irq_i;
    logic [NIRQ-1:0] mask_i;
    logic            ei_i;
    logic            di_i;
    logic            boundary_i;
    logic            reti_i;
    logic [11:0]     pc_i;
    logic            c_i;
    logic            z_i;

    logic            take_o;
    logic            restore_o;
    logic [11:0]     pc_o;
    logic            c_o;
    logic            z_o;
    logic            ie_o;
    logic [SP_W-1:0] depth_o;
    logic            err_o;

    modport master (
        output irq_i, mask_i, ei_i, di_i, boundary_i, reti_i, pc_i, c_i, z_i,
        input  take_o, restore_o, pc_o, c_o, z_o, ie_o, depth_o, err_o
    );

    modport slave (
        input  irq_i, mask_i, ei_i, di_i, boundary_i, reti_i, pc_i, c_i, z_i,
        output take_o, restore_o, pc_o, c_o, z_o, ie_o, depth_o, err_o
    );
endinterface

// File: rtl/int_ctrl.sv
// Nestable prioritised interrupt controller: latches request edges, pushes
// {PC, C, Z} on a take, supplies the vector, and pops the context on RETI.
module int_ctrl #(
    parameter int          NIRQ     = 4,
    parameter int          DEPTH    = 4,
    parameter logic [11:0] VEC_BASE = 12'hF00
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      cen,
    int_ctrl_if.slave bus
);
    localparam int IDX_W = (NIRQ > 1) ? $clog2(NIRQ) : 1;
    localparam int AW    = $clog2(DEPTH);
    localparam int SP_W  = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VECTOR = 2'd1,
        ST_RETURN = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [NIRQ-1:0]  pend_r;
    logic [NIRQ-1:0]  irq_prev_r;
    logic             ie_r;
    logic             err_r;
    logic [SP_W-1:0]  sp_r;
    logic [IDX_W-1:0] idx_r;
    logic [11:0]      pop_pc_r;
    logic             pop_c_r;
    logic             pop_z_r;
    logic [13:0]      stack_r [DEPTH];

    logic [NIRQ-1:0]  eligible_s;
    logic [NIRQ-1:0]  edge_s;
    logic [NIRQ-1:0]  clr_s;
    logic [NIRQ-1:0]  pend_nxt_s;
    logic [IDX_W-1:0] win_s;
    logic             stack_full_s;
    logic             stack_empty_s;
    logic             take_s;
    logic             pop_s;
    logic             reti_err_s;
    logic             ie_nxt_s;
    logic [AW-1:0]    push_idx_s;
    logic [AW-1:0]    pop_idx_s;
    logic             take_out_s;
    logic             rest_out_s;
    logic [11:0]      pc_out_s;

    // Vector address for an irq index; wraps within the 12-bit PC space.
    function automatic logic [11:0] vec_addr_f(input logic [IDX_W-1:0] idx);
        logic [11:0] off;
        off = 12'(idx) << 2;
        return VEC_BASE + off;
    endfunction

    // Stack pointer decode: sp_r counts entries, so the top lives at sp_r-1.
    always_comb begin
        stack_full_s  = (sp_r == SP_W'(DEPTH));
        stack_empty_s = (sp_r == '0);
        push_idx_s    = sp_r[AW-1:0];
        pop_idx_s     = sp_r[AW-1:0] - AW'(1);
    end

    // Priority pick: scanning downwards leaves the lowest eligible index.
    always_comb begin
        eligible_s = pend_r & bus.mask_i;
        win_s      = '0;
        for (int k = NIRQ - 1; k >= 0; k--) begin
            if (eligible_s[k]) begin
                win_s = IDX_W'(k);
            end else begin
                win_s = win_s;
            end
        end
    end

    // Next-state decode; RETI is checked first so it beats a pending take.
    always_comb begin
        state_nxt_s = state_r;
        take_s      = 1'b0;
        pop_s       = 1'b0;
        reti_err_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.reti_i) begin
                    if (!stack_empty_s) begin
                        pop_s       = 1'b1;
                        state_nxt_s = ST_RETURN;
                    end else begin
                        reti_err_s  = 1'b1;
                    end
                end else if (ie_r && bus.boundary_i && (|eligible_s) && !stack_full_s) begin
                    take_s      = 1'b1;
                    state_nxt_s = ST_VECTOR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_VECTOR: state_nxt_s = ST_IDLE;
            ST_RETURN: state_nxt_s = ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // Pending and IE update; a fresh edge beats the take clear on the same bit.
    always_comb begin
        edge_s = bus.irq_i & ~irq_prev_r;
        clr_s  = '0;
        if (take_s) begin
            clr_s[win_s] = 1'b1;
        end else begin
            clr_s = '0;
        end
        pend_nxt_s = (pend_r & ~clr_s) | edge_s;

        if (take_s) begin
            ie_nxt_s = 1'b0;
        end else if (pop_s) begin
            ie_nxt_s = 1'b1;
        end else if (bus.di_i) begin
            ie_nxt_s = 1'b0;
        end else if (bus.ei_i) begin
            ie_nxt_s = 1'b1;
        end else begin
            ie_nxt_s = ie_r;
        end
    end

    // Control state, pending, IE, stack pointer and popped-context register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            pend_r     <= '0;
            irq_prev_r <= '0;
            ie_r       <= 1'b0;
            err_r      <= 1'b0;
            sp_r       <= '0;
            idx_r      <= '0;
            pop_pc_r   <= 12'h000;
            pop_c_r    <= 1'b0;
            pop_z_r    <= 1'b0;
        end else if (cen) begin
            state_r    <= state_nxt_s;
            pend_r     <= pend_nxt_s;
            irq_prev_r <= bus.irq_i;
            ie_r       <= ie_nxt_s;
            if (reti_err_s) begin
                err_r <= 1'b1;
            end
            if (take_s) begin
                sp_r  <= sp_r + SP_W'(1);
                idx_r <= win_s;
            end else if (pop_s) begin
                sp_r                          <= sp_r - SP_W'(1);
                {pop_pc_r, pop_c_r, pop_z_r}  <= stack_r[pop_idx_s];
            end
        end
    end

    // Context stack storage, written only on a take.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stack_r[i] <= 14'h0000;
            end
        end else if (cen && take_s) begin
            stack_r[push_idx_s] <= {bus.pc_i, bus.c_i, bus.z_i};
        end
    end

    // Output decode; pulses are suppressed while the clock enable is low.
    always_comb begin
        take_out_s = cen & (state_r == ST_VECTOR);
        rest_out_s = cen & (state_r == ST_RETURN);
        if (take_out_s) begin
            pc_out_s = vec_addr_f(idx_r);
        end else if (rest_out_s) begin
            pc_out_s = pop_pc_r;
        end else begin
            pc_out_s = 12'h000;
        end
    end

    assign bus.take_o    = take_out_s;
    assign bus.restore_o = rest_out_s;
    assign bus.pc_o      = pc_out_s;
    assign bus.c_o       = rest_out_s & pop_c_r;
    assign bus.z_o       = rest_out_s & pop_z_r;
    assign bus.ie_o      = ie_r;
    assign bus.depth_o   = sp_r;
    assign bus.err_o     = err_r;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: take/restore, priority, nesting, conflicts,
// clock enable and reset, all against hand-computed values.
module tb_int_ctrl;
    logic clk;
    logic rst;
    logic cen;
    int   total_cnt = 0;
    int   bad_cnt   = 0;

    int_ctrl_if #(.NIRQ(4), .DEPTH(4)) bus ();

    int_ctrl #(.NIRQ(4), .DEPTH(4), .VEC_BASE(12'hF00)) dut (
        .clk (clk),
        .rst (rst),
        .cen (cen),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [11:0] exp_pc [4];

    initial begin
        exp_pc[0] = 12'h3AA;
        exp_pc[1] = 12'h302;
        exp_pc[2] = 12'h301;
        exp_pc[3] = 12'h300;

        rst = 1'b1;
        cen = 1'b1;
        bus.irq_i      = 4'h0;
        bus.mask_i     = 4'hF;
        bus.ei_i       = 1'b0;
        bus.di_i       = 1'b0;
        bus.boundary_i = 1'b0;
        bus.reti_i     = 1'b0;
        bus.pc_i       = 12'h000;
        bus.c_i        = 1'b0;
        bus.z_i        = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_val("rst_take",  32'(bus.take_o),    32'd0);
        check_val("rst_rest",  32'(bus.restore_o), 32'd0);
        check_val("rst_pc",    32'(bus.pc_o),      32'd0);
        check_val("rst_ie",    32'(bus.ie_o),      32'd0);
        check_val("rst_depth", 32'(bus.depth_o),   32'd0);
        check_val("rst_err",   32'(bus.err_o),     32'd0);

        // Basic take / restore
        bus.ei_i = 1'b1;
        tick();
        bus.ei_i = 1'b0;
        check_val("ei_set", 32'(bus.ie_o), 32'd1);
        bus.boundary_i = 1'b1;
        bus.pc_i = 12'h123;
        bus.c_i  = 1'b1;
        bus.z_i  = 1'b0;
        bus.irq_i = 4'b0100;
        tick();
        check_val("t1_no_early_take", 32'(bus.take_o), 32'd0);
        tick();
        check_val("t1_take",  32'(bus.take_o),  32'd1);
        check_val("t1_vec",   32'(bus.pc_o),    32'h0F08);
        check_val("t1_ie",    32'(bus.ie_o),    32'd0);
        check_val("t1_depth", 32'(bus.depth_o), 32'd1);
        tick();
        check_val("t1_take_end", 32'(bus.take_o), 32'd0);
        check_val("t1_pc_idle",  32'(bus.pc_o),   32'd0);
        bus.reti_i = 1'b1;
        tick();
        bus.reti_i = 1'b0;
        check_val("t1_rest",   32'(bus.restore_o), 32'd1);
        check_val("t1_rpc",    32'(bus.pc_o),      32'h0123);
        check_val("t1_rc",     32'(bus.c_o),       32'd1);
        check_val("t1_rz",     32'(bus.z_o),       32'd0);
        check_val("t1_rie",    32'(bus.ie_o),      32'd1);
        check_val("t1_rdepth", 32'(bus.depth_o),   32'd0);
        tick();
        bus.irq_i = 4'h0;
        tick();

        // Priority with all lines enabled: irq1 first, irq3 after RETI
        bus.irq_i = 4'b1010;
        bus.pc_i  = 12'h200;
        bus.c_i   = 1'b0;
        bus.z_i   = 1'b1;
        tick();
        tick();
        check_val("p1_take", 32'(bus.take_o), 32'd1);
        check_val("p1_vec",  32'(bus.pc_o),   32'h0F04);
        tick();
        bus.reti_i = 1'b1;
        tick();
        bus.reti_i = 1'b0;
        check_val("p1_rpc", 32'(bus.pc_o), 32'h0200);
        check_val("p1_rz",  32'(bus.z_o),  32'd1);
        tick();
        check_val("p1_gap", 32'(bus.take_o), 32'd0);
        tick();
        check_val("p1_take3", 32'(bus.take_o), 32'd1);
        check_val("p1_vec3",  32'(bus.pc_o),   32'h0F0C);
        tick();
        bus.reti_i = 1'b1;
        tick();
        bus.reti_i = 1'b0;
        tick();

        // Masking: only irq3 enabled
        bus.irq_i = 4'h0;
        tick();
        bus.mask_i = 4'b1000;
        bus.irq_i  = 4'b1010;
        bus.pc_i   = 12'h210;
        tick();
        tick();
        check_val("m_take", 32'(bus.take_o), 32'd1);
        check_val("m_vec",  32'(bus.pc_o),   32'h0F0C);
        tick();
        bus.reti_i = 1'b1;
        tick();
        bus.reti_i = 1'b0;
        check_val("m_rpc", 32'(bus.pc_o), 32'h0210);
        tick();
        tick();
        check_val("m_masked_hold", 32'(bus.take_o), 32'd0);
        bus.mask_i = 4'hF;
        tick();
        check_val("m_unmask_vec", 32'(bus.pc_o), 32'h0F04);
        tick();
        bus.reti_i = 1'b1;
        tick();
        bus.reti_i = 1'b0;
        tick();

        // Nesting to full
        bus.irq_i = 4'h0;
        tick();
        for (int j = 0; j < 4; j++) begin
            bus.pc_i     = 12'h300 + 12'(j);
            bus.irq_i[j] = 1'b1;
            tick();
            tick();
            check_val("n_vec",   32'(bus.pc_o),    32'h0F00 + 32'(4 * j));
            check_val("n_depth", 32'(bus.depth_o), 32'(j + 1));
            bus.ei_i = 1'b1;
            tick();
            bus.ei_i = 1'b0;
            check_val("n_ie", 32'(bus.ie_o), 32'd1);
        end
        bus.pc_i  = 12'h3AA;
        bus.irq_i = 4'b1110;
        tick();
        bus.irq_i = 4'b1111;
        tick();
        tick();
        tick();
        check_val("full_blocked", 32'(bus.take_o),  32'd0);
        check_val("full_depth",   32'(bus.depth_o), 32'd4);
        bus.reti_i = 1'b1;
        tick();
        bus.reti_i = 1'b0;
        check_val("full_rpc",   32'(bus.pc_o),    32'h0303);
        check_val("full_rdepth", 32'(bus.depth_o), 32'd3);
        tick();
        tick();
        check_val("full_take5", 32'(bus.take_o),  32'd1);
        check_val("full_vec5",  32'(bus.pc_o),    32'h0F00);
        check_val("full_dep5",  32'(bus.depth_o), 32'd4);
        tick();
        for (int j = 0; j < 4; j++) begin
            bus.reti_i = 1'b1;
            tick();
            bus.reti_i = 1'b0;
            check_val("unwind_pc", 32'(bus.pc_o), 32'(exp_pc[j]));
            tick();
        end
        check_val("unwind_depth", 32'(bus.depth_o), 32'd0);

        // RETI and take condition in the same cycle
        bus.irq_i = 4'h0;
        tick();
        bus.pc_i  = 12'h400;
        bus.irq_i = 4'b0100;
        tick();
        tick();
        check_val("c1_vec", 32'(bus.pc_o), 32'h0F08);
        bus.ei_i  = 1'b1;
        bus.irq_i = 4'b0110;
        tick();
        bus.ei_i   = 1'b0;
        bus.reti_i = 1'b1;
        tick();
        bus.reti_i = 1'b0;
        check_val("c1_rest",  32'(bus.restore_o), 32'd1);
        check_val("c1_notake", 32'(bus.take_o),   32'd0);
        check_val("c1_rpc",   32'(bus.pc_o),      32'h0400);
        tick();
        check_val("c1_gap", 32'(bus.take_o), 32'd0);
        tick();
        check_val("c1_late_take", 32'(bus.take_o), 32'd1);
        check_val("c1_late_vec",  32'(bus.pc_o),   32'h0F04);
        tick();
        bus.reti_i = 1'b1;
        tick();
        bus.reti_i = 1'b0;
        tick();

        // ei and di together
        bus.ei_i = 1'b1;
        bus.di_i = 1'b1;
        tick();
        check_val("c2_di_wins", 32'(bus.ie_o), 32'd0);
        bus.di_i = 1'b0;
        tick();
        bus.ei_i = 1'b0;
        check_val("c2_ei", 32'(bus.ie_o), 32'd1);

        // RETI with empty stack
        bus.reti_i = 1'b1;
        tick();
        bus.reti_i = 1'b0;
        check_val("c3_err",    32'(bus.err_o),     32'd1);
        check_val("c3_norest", 32'(bus.restore_o), 32'd0);
        check_val("c3_depth",  32'(bus.depth_o),   32'd0);
        tick();
        check_val("c3_sticky", 32'(bus.err_o), 32'd1);

        // Clock enable low across an irq edge
        bus.irq_i = 4'h0;
        tick();
        cen = 1'b0;
        bus.irq_i = 4'b0001;
        bus.di_i  = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            check_val("cen_notake", 32'(bus.take_o), 32'd0);
            check_val("cen_ie_hold", 32'(bus.ie_o), 32'd1);
        end
        bus.irq_i = 4'h0;
        bus.di_i  = 1'b0;
        tick();
        cen = 1'b1;
        tick();
        tick();
        tick();
        check_val("cen_no_pend", 32'(bus.take_o),  32'd0);
        check_val("cen_depth",   32'(bus.depth_o), 32'd0);

        // Pulse gating by cen, then reset in the VECTOR cycle
        bus.irq_i = 4'b0100;
        tick();
        tick();
        check_val("r_take", 32'(bus.take_o), 32'd1);
        cen = 1'b0;
        #1;
        check_val("r_gate_take", 32'(bus.take_o), 32'd0);
        check_val("r_gate_pc",   32'(bus.pc_o),   32'd0);
        rst = 1'b1;
        bus.irq_i = 4'h0;
        tick();
        rst = 1'b0;
        cen = 1'b1;
        check_val("r_take_after", 32'(bus.take_o),  32'd0);
        check_val("r_depth",      32'(bus.depth_o), 32'd0);
        check_val("r_ie",         32'(bus.ie_o),    32'd0);
        check_val("r_err",        32'(bus.err_o),   32'd0);
        tick();
        check_val("r_no_pulse", 32'(bus.take_o), 32'd0);
        bus.ei_i = 1'b1;
        tick();
        bus.ei_i = 1'b0;
        tick();
        tick();
        check_val("r_pend_clear", 32'(bus.take_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end
endmodule
